cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Shares the N CDB slots among all FU result sources (ALU, MULT, BRANCH, LDST).
//  It sits between the issue stage and the complete stage.
//  Each cycle it grants up to N requesters using rotating priority with an anti-starvation override.
//  It registers the slot->FU mapping for the following cycle and drives per-FU backpressure (fu_free).
// PARAMETERS
//  N         `N               CDB slots per cycle (2 in the default configuration)
//  NUM_REQ   `NUM_FU_TOTAL    requesters; one bit per FU, packed ALU,MULT,BRANCH,LDST
//  AGE_MAX   4                denied-cycle count at which a requester becomes starving
//  IDX_W     $clog2(NUM_REQ)  requester index width
// PORTS
//  clock          in   1              single clock, rising edge
//  reset          in   1              asynchronous, active-low reset
//  flush          in   1              mispredict squash; kills the in-flight selection
//  fu_req         in   NUM_REQ        FU will present a result next cycle (mult/ldst: second-to-last stage)
//  complete_gnt_bus out [N][NUM_REQ]  one-hot grant per slot, combinational from fu_req and state
//  fu_free        out  NUM_REQ        ~fu_req | granted; low = FU must hold its pipeline
//  cdb_sel_valid  out  N              registered: slot k is driven in the current cycle
//  cdb_sel_idx    out  [N][IDX_W]     registered: FU index that drives slot k
// BEHAVIOUR
//  Reset (reset==0, async):
//   - ptr=0, all age counters=0, cdb_sel_valid=0, cdb_sel_idx=0.
//   - complete_gnt_bus=0 and fu_free=all-ones while reset is low.
//  Grant, combinational, every cycle:
//   - Phase 1: starving requesters (req && age==AGE_MAX) take slots in ascending index order.
//   - Phase 2: remaining slots go to other requesters, scanning from ptr upward and wrapping mod NUM_REQ.
//   - Slot k gets the k-th pick. At most N grants. No requester is granted twice.
//   - Unused slots have all-zero grant rows.
//  Flush: complete_gnt_bus=0 and fu_free=all-ones in that cycle. On the next edge:
//   - cdb_sel_valid<=0 and all ages<=0.
//   - ptr is unchanged.
//  Registered update at the rising edge (flush==0):
//   - cdb_sel_valid[k] <= |complete_gnt_bus[k]; cdb_sel_idx[k] <= onehot2idx(row k).
//   - Data latency is 1 cycle: grant in cycle t, result on CDB slot k in cycle t+1.
//   - ptr <= (index of the last Phase-2 grant + 1) mod NUM_REQ.
//   - If there is no Phase-2 grant, ptr holds. Phase-1 grants never move ptr.
//   - Wrap NUM_REQ-1 -> 0 explicitly; NUM_REQ need not be a power of 2.
//  Age, per requester:
//   - not requesting, or granted -> 0.
//   - requesting and denied -> age+1, saturating at AGE_MAX.
//  Backpressure:
//   - A denied FU sees fu_free=0 and must hold fu_req and its result stage unchanged next cycle.
//   - The arbiter does not check this.
//  Boundary cases:
//   - More than N starving requesters: lowest indices win. Others stay at AGE_MAX and win next.
//   - fu_req==0: no grants, state holds, ages clear.
//   - NUM_REQ<=N: every requester is granted every cycle.
// STRUCTURE
//  Shared package (sys_defs) holds:
//   - CDB_GNT typedef ([N][NUM_REQ] logic).
//   - FU_ALU_BASE/FU_MULT_BASE/FU_BRANCH_BASE/FU_LDST_BASE index constants.
//   - AGE_MAX default.
//  Sub-module cdb_prio_picker (combinational): picks up to K set bits from a vector, starting at a rotating base.
//   - Instantiated twice: Phase 1 with base 0, Phase 2 with base ptr and Phase-1 winners masked.
//  Sequential state: ptr, age[NUM_REQ], cdb_sel_valid/idx.
// TESTING (N=2, NUM_REQ=8, AGE_MAX=4)
//  1 Reset low mid-traffic, fu_req=8'hFF
//     -> outputs zero and fu_free=8'hFF immediately; after release, first grants go to FU0 and FU1.
//  2 fu_req=8'hFF held 4 cycles
//     -> grants {0,1},{2,3},{4,5},{6,7}; ptr wraps to 0; cdb_sel_idx matches one cycle later.
//  3 fu_req=8'h81 with ptr=7
//     -> slot0=FU7, slot1=FU0; next ptr=1; fu_free=8'hFF.
//  4 FU5 req held while FU0-4 are re-requested every cycle, ptr forced low
//     -> FU5 is granted no later than its 5th request cycle and its age resets to 0.
//  5 flush asserted with fu_req=8'h0F
//     -> no grants that cycle; next cycle cdb_sel_valid=0 and ptr unchanged.
//  6 single requester 8'h10 for 3 cycles
//     -> slot0=FU4 every cycle, slot1 row zero, cdb_sel_valid=2'b01.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB arbitration definitions: default sizing, FU index map, grant bus type
// and the modular pointer increment used for rotating priority.
package cdb_arbiter_pkg;

   localparam int unsigned CDB_N        = 2;
   localparam int unsigned NUM_ALU      = 3;
   localparam int unsigned NUM_MULT     = 2;
   localparam int unsigned NUM_BRANCH   = 1;
   localparam int unsigned NUM_LDST     = 2;

   // Requester vector is packed ALU, MULT, BRANCH, LDST from bit 0 upward.
   localparam int unsigned FU_ALU_BASE    = 0;
   localparam int unsigned FU_MULT_BASE   = FU_ALU_BASE + NUM_ALU;
   localparam int unsigned FU_BRANCH_BASE = FU_MULT_BASE + NUM_MULT;
   localparam int unsigned FU_LDST_BASE   = FU_BRANCH_BASE + NUM_BRANCH;
   localparam int unsigned NUM_FU_TOTAL   = FU_LDST_BASE + NUM_LDST;

   localparam int unsigned CDB_AGE_MAX  = 4;

   typedef logic [CDB_N-1:0][NUM_FU_TOTAL-1:0] CDB_GNT;

   // Explicit wrap so the requester count need not be a power of two.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Arbiter <-> FU/CDB bundle: requests and flush in, per-slot grants,
// backpressure and the registered slot selection out.
interface cdb_arbiter_if #(
   parameter int unsigned N       = 2,
   parameter int unsigned NUM_REQ = 8,
   parameter int unsigned IDX_W   = 3
);
   logic                          flush;
   logic [NUM_REQ-1:0]            fu_req;
   logic [N-1:0][NUM_REQ-1:0]     complete_gnt_bus;
   logic [NUM_REQ-1:0]            fu_free;
   logic [N-1:0]                  cdb_sel_valid;
   logic [N-1:0][IDX_W-1:0]       cdb_sel_idx;

   modport master (
      input  flush, fu_req,
      output complete_gnt_bus, fu_free, cdb_sel_valid, cdb_sel_idx
   );

   modport slave (
      output flush, fu_req,
      input  complete_gnt_bus, fu_free, cdb_sel_valid, cdb_sel_idx
   );
endinterface

// File: rtl/cdb_prio_picker.sv
// Combinational picker: returns up to K set bits of req_i, scanning upward from
// base_i with wrap; pick k is the k-th set bit encountered.
module cdb_prio_picker #(
   parameter int unsigned NUM_REQ = 8,
   parameter int unsigned K       = 2,
   parameter int unsigned IDX_W   = 3
) (
   input  logic [NUM_REQ-1:0]     req_i,
   input  logic [IDX_W-1:0]       base_i,
   output logic [K-1:0]           pick_valid_o,
   output logic [K-1:0][IDX_W-1:0] pick_idx_o
);
   localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;

   always_comb begin
      int unsigned cnt;
      int unsigned pos;
      cnt          = 0;
      pos          = 0;
      pick_valid_o = '0;
      pick_idx_o   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         pos = 32'(base_i) + i;
         if (pos >= NUM_REQ) begin
            pos = pos - NUM_REQ;
         end
         if (req_i[pos[IDX_W-1:0]] && (cnt < K)) begin
            pick_valid_o[cnt[KW-1:0]] = 1'b1;
            pick_idx_o[cnt[KW-1:0]]   = IDX_W'(pos);
            cnt = cnt + 1;
         end
      end
   end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB slot arbiter: starving FUs first (lowest index wins), then rotating priority
// from ptr; registers the slot->FU selection for the following cycle.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned N       = CDB_N,
   parameter int unsigned NUM_REQ = NUM_FU_TOTAL,
   parameter int unsigned AGE_MAX = CDB_AGE_MAX,
   parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   cdb_arbiter_if.master bus
);
   localparam int unsigned AGE_W = $clog2(AGE_MAX + 1);
   localparam int unsigned KW    = (N > 1) ? $clog2(N) : 1;

   logic [NUM_REQ-1:0]            starving;
   logic [NUM_REQ-1:0]            p1_mask;
   logic [N-1:0]                  p1_valid, p2_valid;
   logic [N-1:0][IDX_W-1:0]       p1_idx, p2_idx;
   logic [N-1:0]                  slot_valid;
   logic [N-1:0][IDX_W-1:0]       slot_idx;
   logic                          p2_any;
   logic [IDX_W-1:0]              p2_last;
   logic [NUM_REQ-1:0]            granted;
   logic                          active;

   logic [IDX_W-1:0]              ptr_q, ptr_d;
   logic [NUM_REQ-1:0][AGE_W-1:0] age_q, age_d;
   logic [N-1:0]                  sel_valid_q;
   logic [N-1:0][IDX_W-1:0]       sel_idx_q;

   // Grants are suppressed outright while in reset or squashing.
   assign active = rst_ni && !bus.flush;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign starving[gi] = bus.fu_req[gi] && (age_q[gi] == AGE_W'(AGE_MAX));
      assign age_d[gi]    = (!bus.fu_req[gi] || granted[gi]) ? '0 :
                            (age_q[gi] == AGE_W'(AGE_MAX))   ? age_q[gi] :
                            age_q[gi] + AGE_W'(1);
   end

   cdb_prio_picker #(.NUM_REQ(NUM_REQ), .K(N), .IDX_W(IDX_W)) u_phase1 (
      .req_i        (starving),
      .base_i       ('0),
      .pick_valid_o (p1_valid),
      .pick_idx_o   (p1_idx)
   );

   always_comb begin
      p1_mask = '0;
      for (int unsigned k = 0; k < N; k++) begin
         p1_mask = p1_mask | (NUM_REQ'(p1_valid[k]) << p1_idx[k]);
      end
   end

   cdb_prio_picker #(.NUM_REQ(NUM_REQ), .K(N), .IDX_W(IDX_W)) u_phase2 (
      .req_i        (bus.fu_req & ~p1_mask),
      .base_i       (ptr_q),
      .pick_valid_o (p2_valid),
      .pick_idx_o   (p2_idx)
   );

   // Phase-1 picks are packed from slot 0, so Phase-2 picks fill the slots after them.
   always_comb begin
      logic [KW:0] j;
      j          = '0;
      slot_valid = '0;
      slot_idx   = '0;
      p2_any     = 1'b0;
      p2_last    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (p1_valid[k]) begin
            slot_valid[k] = 1'b1;
            slot_idx[k]   = p1_idx[k];
         end else begin
            if (p2_valid[j[KW-1:0]]) begin
               slot_valid[k] = 1'b1;
               slot_idx[k]   = p2_idx[j[KW-1:0]];
               p2_any        = 1'b1;
               p2_last       = p2_idx[j[KW-1:0]];
            end
            j = j + 1'b1;
         end
      end
   end

   always_comb begin
      granted = '0;
      for (int unsigned k = 0; k < N; k++) begin
         granted = granted | (NUM_REQ'(slot_valid[k]) << slot_idx[k]);
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_slot
      assign bus.complete_gnt_bus[gi] = (active && slot_valid[gi]) ?
                                        (NUM_REQ'(1) << slot_idx[gi]) : '0;
   end

   assign bus.fu_free       = active ? (~bus.fu_req | granted) : '1;
   assign bus.cdb_sel_valid = sel_valid_q;
   assign bus.cdb_sel_idx   = sel_idx_q;

   assign ptr_d = p2_any ? IDX_W'(wrap_inc(32'(p2_last), NUM_REQ)) : ptr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q       <= '0;
         age_q       <= '0;
         sel_valid_q <= '0;
         sel_idx_q   <= '0;
      end else if (bus.flush) begin
         sel_valid_q <= '0;
         age_q       <= '0;
      end else begin
         ptr_q       <= ptr_d;
         age_q       <= age_d;
         sel_valid_q <= slot_valid;
         sel_idx_q   <= slot_idx;
      end
   end
endmodule
